// File: rtl/regfile_bypass_unit.sv
// regfile_bypass_unit: architectural register file, D->E operand latch and N-source bypass network.
// Emits resolved E-stage operands plus a per-operand ready flag for load-use stall generation.
module regfile_bypass_unit #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_STG = 3,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [NUM_RD*AW-1:0]      i_rs_addr_d,
  input  logic [NUM_STG-1:0]        i_stg_we,
  input  logic [NUM_STG*AW-1:0]     i_stg_rd,
  input  logic [NUM_STG*XLEN-1:0]   i_stg_data,
  input  logic [NUM_STG-1:0]        i_stg_dvalid,
  input  logic                      i_wb_we,
  input  logic [AW-1:0]             i_wb_addr,
  input  logic [XLEN-1:0]           i_wb_data,
  output logic [NUM_RD*AW-1:0]      o_rs_addr_e,
  output logic [NUM_RD*XLEN-1:0]    o_rs_data_e,
  output logic [NUM_RD-1:0]         o_rs_ready_e,
  output logic [NUM_RD-1:0]         o_fwd_hit_e
);
  logic [XLEN-1:0]        r_regs [NREGS];
  logic [NUM_RD*AW-1:0]   r_addr_e;
  logic [NUM_RD*XLEN-1:0] r_raw_e;
  logic [NUM_RD*AW-1:0]   w_addr_n;
  logic [NUM_RD*XLEN-1:0] w_raw_n;
  logic [AW-1:0]          w_a;

  // A stall re-reads at the held address so writebacks landing mid-stall are kept.
  always_comb begin
    w_addr_n = i_flush ? '0 : i_stall ? r_addr_e : i_rs_addr_d;
    w_raw_n  = '0;
    for (int i = 0; i < NUM_RD; i++)
      w_raw_n[i*XLEN +: XLEN] = (w_addr_n[i*AW +: AW] == '0) ? '0 :
                                (i_wb_we && i_wb_addr == w_addr_n[i*AW +: AW]) ? i_wb_data :
                                r_regs[w_addr_n[i*AW +: AW]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NREGS; j++) r_regs[j] <= '0;
      r_addr_e <= '0;
      r_raw_e  <= '0;
    end else begin
      if (i_wb_we && i_wb_addr != '0) r_regs[i_wb_addr] <= i_wb_data;
      r_addr_e <= w_addr_n;
      r_raw_e  <= w_raw_n;
    end
  end

  // Scan oldest to youngest so the youngest matching stage overrides, ready or not.
  always_comb begin
    o_rs_data_e  = '0;
    o_rs_ready_e = '1;
    o_fwd_hit_e  = '0;
    w_a          = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_a = r_addr_e[i*AW +: AW];
      o_rs_data_e[i*XLEN +: XLEN] = (i_wb_we && i_wb_addr == w_a) ? i_wb_data : r_raw_e[i*XLEN +: XLEN];
      for (int k = NUM_STG - 1; k >= 0; k--)
        if (i_stg_we[k] && i_stg_rd[k*AW +: AW] == w_a) begin
          o_rs_data_e[i*XLEN +: XLEN] = i_stg_data[k*XLEN +: XLEN];
          o_rs_ready_e[i]             = i_stg_dvalid[k];
          o_fwd_hit_e[i]              = 1'b1;
        end
      if (w_a == '0) begin
        o_rs_data_e[i*XLEN +: XLEN] = '0;
        o_rs_ready_e[i]             = 1'b1;
        o_fwd_hit_e[i]              = 1'b0;
      end
    end
  end

  assign o_rs_addr_e = r_addr_e;
endmodule

// File: tb/tb_regfile_bypass_unit.sv
// tb_regfile_bypass_unit: directed vector table, hand-written reset sequence and randomized
// traffic checked against an array-based reference model of the register file and E latch.
module tb_regfile_bypass_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, wb_we;
  logic [4:0]  rsd [2];
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  swe, sdv;
  logic [4:0]  srd [3];
  logic [31:0] sdat [3];
  logic [9:0]  o_addr;
  logic [63:0] o_data;
  logic [1:0]  o_ready, o_hit;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_rf [32];
  logic [4:0]  m_ae [2];
  logic [31:0] m_raw [2];

  regfile_bypass_unit dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_rs_addr_d({rsd[1], rsd[0]}),
    .i_stg_we(swe), .i_stg_rd({srd[2], srd[1], srd[0]}),
    .i_stg_data({sdat[2], sdat[1], sdat[0]}), .i_stg_dvalid(sdv),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_rs_addr_e(o_addr), .o_rs_data_e(o_data), .o_rs_ready_e(o_ready), .o_fwd_hit_e(o_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall, flush;
    logic [4:0]  d0;
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic [2:0]  swe;
    logic [14:0] srd;
    logic [95:0] sdat;
    logic [2:0]  sdv;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        er, eh;
  } vec_t;
  vec_t tbl [14];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    for (int i = 0; i < 2; i++) begin
      m_ae[i]  = '0;
      m_raw[i] = '0;
    end
  endfunction

  // Writeback lands first, then the latch reads the updated file: same-cycle forwarding for free.
  function automatic void model_edge();
    logic [4:0] na [2];
    for (int i = 0; i < 2; i++) na[i] = flush ? 5'd0 : stall ? m_ae[i] : rsd[i];
    if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    for (int i = 0; i < 2; i++) begin
      m_ae[i]  = na[i];
      m_raw[i] = (na[i] == 0) ? 32'd0 : m_rf[na[i]];
    end
  endfunction

  function automatic void expect_op(input int i, output logic [4:0] a, output logic [31:0] d,
                                    output logic r, output logic h);
    bit found = 0;
    a = m_ae[i];
    d = 0; r = 1; h = 0;
    if (a != 0) begin
      for (int k = 0; k < 3; k++)
        if (!found && swe[k] && srd[k] == a) begin
          found = 1; d = sdat[k]; r = sdv[k]; h = 1;
        end
      if (!found) d = (wb_we && wb_addr == a) ? wb_data : m_raw[i];
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [4:0] a; logic [31:0] d; logic r, h;
    for (int i = 0; i < 2; i++) begin
      expect_op(i, a, d, r, h);
      cmp($sformatf("%s_op%0d_addr", tag, i), 32'(o_addr[i*5 +: 5]), 32'(a));
      cmp($sformatf("%s_op%0d_data", tag, i), o_data[i*32 +: 32], d);
      cmp($sformatf("%s_op%0d_ready", tag, i), 32'(o_ready[i]), 32'(r));
      cmp($sformatf("%s_op%0d_hit", tag, i), 32'(o_hit[i]), 32'(h));
    end
  endtask

  task automatic chk_op0(input string tag, input logic [4:0] a, input logic [31:0] d,
                         input logic r, input logic h);
    cmp({tag, "_addr"}, 32'(o_addr[4:0]), 32'(a));
    cmp({tag, "_data"}, o_data[31:0], d);
    cmp({tag, "_ready"}, 32'(o_ready[0]), 32'(r));
    cmp({tag, "_hit"}, 32'(o_hit[0]), 32'(h));
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    rsd[0] = 0; rsd[1] = 0; swe = 0; sdv = '1;
    for (int k = 0; k < 3; k++) begin
      srd[k] = 0; sdat[k] = 0;
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #3;
    chk_model("in_reset");
    #9 rst_n = 1;
    chk_model("post_reset");

    //          stall flush d0  we  wa     wd            swe     srd {s2,s1,s0}         sdat {s2,s1,s0}                  sdv     ea     ed            er eh
    tbl[0]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd5, 32'hDEADBEEF, 3'b000, 15'd0,                   96'd0,                            3'b111, 5'd0,  32'h0,        1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 5'd5,  1'b0, 5'd0, 32'h0,        3'b000, 15'd0,                   96'd0,                            3'b111, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd7,  1'b1, 5'd7, 32'h77,       3'b000, 15'd0,                   96'd0,                            3'b111, 5'd7,  32'h77,       1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd7,  1'b0, 5'd0, 32'h0,        3'b101, {5'd7, 5'd0, 5'd7},      {32'h33, 32'h0, 32'h11},          3'b111, 5'd7,  32'h11,       1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 5'd9,  1'b0, 5'd0, 32'h0,        3'b011, {5'd0, 5'd9, 5'd9},      {32'h0, 32'h22, 32'hAA},          3'b010, 5'd9,  32'hAA,       1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 5'd9,  1'b0, 5'd0, 32'h0,        3'b010, {5'd0, 5'd9, 5'd9},      {32'h0, 32'h22, 32'hAA},          3'b010, 5'd9,  32'h22,       1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 5'd5,  1'b0, 5'd0, 32'h0,        3'b000, 15'd0,                   96'd0,                            3'b111, 5'd0,  32'h0,        1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd0, 32'hFFFFFFFF, 3'b001, {5'd0, 5'd0, 5'd0},      {32'h0, 32'h0, 32'h55},           3'b111, 5'd0,  32'h0,        1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5'd3,  1'b0, 5'd0, 32'h0,        3'b000, 15'd0,                   96'd0,                            3'b111, 5'd3,  32'h0,        1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 5'd12, 1'b0, 5'd0, 32'h0,        3'b000, 15'd0,                   96'd0,                            3'b111, 5'd3,  32'h0,        1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 5'd12, 1'b1, 5'd3, 32'h42,       3'b000, 15'd0,                   96'd0,                            3'b111, 5'd3,  32'h42,       1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 5'd12, 1'b0, 5'd0, 32'h0,        3'b000, 15'd0,                   96'd0,                            3'b111, 5'd3,  32'h42,       1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'd12, 1'b0, 5'd0, 32'h0,        3'b000, 15'd0,                   96'd0,                            3'b111, 5'd12, 32'h0,        1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0,        3'b001, {5'd0, 5'd0, 5'd0},      {32'h0, 32'h0, 32'h99},           3'b000, 5'd0,  32'h0,        1'b1, 1'b0};

    for (int n = 0; n < 14; n++) begin
      stall = tbl[n].stall; flush = tbl[n].flush; rsd[0] = tbl[n].d0; rsd[1] = 0;
      wb_we = tbl[n].wb_we; wb_addr = tbl[n].wb_a; wb_data = tbl[n].wb_d;
      swe = tbl[n].swe; sdv = tbl[n].sdv;
      for (int k = 0; k < 3; k++) begin
        srd[k]  = tbl[n].srd[k*5 +: 5];
        sdat[k] = tbl[n].sdat[k*32 +: 32];
      end
      tick();
      chk_op0($sformatf("vec%0d", n), tbl[n].ea, tbl[n].ed, tbl[n].er, tbl[n].eh);
    end

    // Asynchronous reset asserted mid-cycle while a stall is pending.
    idle_inputs();
    rsd[0] = 5;
    tick();
    chk_op0("pre_areset", 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    stall = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_op0("areset_now", 5'd0, 32'h0, 1'b1, 1'b0);
    #2 rst_n = 1;
    stall = 0;
    tick();
    chk_op0("areset_x5", 5'd5, 32'h0, 1'b1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      rsd[0]  = 5'($urandom_range(0, 7));
      rsd[1]  = 5'($urandom_range(0, 7));
      wb_we   = 1'($urandom_range(0, 1));
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      swe     = 3'($urandom_range(0, 7));
      sdv     = 3'($urandom_range(0, 7));
      tick();
      swe = 3'($urandom_range(0, 7));
      sdv = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        srd[k]  = 5'($urandom_range(0, 7));
        sdat[k] = $urandom;
      end
      #1;
      chk_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_bypass_unit.md
Name: regfile_bypass_unit

Overview:
- Parametrised successor to the fixed three-source forwarding muxes (M/W/U) and separate register file of the 6-stage core.
- Combines the architectural register file, the D→E operand latch and an N-source bypass network with per-operand readiness.
- Sits between decode and the ALU input muxes.
- Produces fully resolved E-stage operands and a per-operand not-ready flag for load-use stall generation.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; register 0 reads zero; must be a power of two.
- NUM_RD, 2, number of read operands per instruction.
- NUM_STG, 3, number of in-flight producer stages offered for bypass; index 0 is the youngest.
- AW (local), $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the E latch (addresses kept, data refreshed).
- flush  in  1  load a bubble into the E latch.
- rs_addr_d  in  NUM_RD*AW  D-stage source addresses; operand i occupies [i*AW +: AW].
- stg_we  in  NUM_STG  stage k will write a register.
- stg_rd  in  NUM_STG*AW  stage k destination register.
- stg_data  in  NUM_STG*XLEN  stage k result.
- stg_dvalid  in  NUM_STG  stage k result is available this cycle (0 = load still pending).
- wb_we  in  1  architectural write enable.
- wb_addr  in  AW  write address.
- wb_data  in  XLEN  write data.
- rs_addr_e  out  NUM_RD*AW  latched E-stage addresses.
- rs_data_e  out  NUM_RD*XLEN  resolved E-stage operands.
- rs_ready_e  out  NUM_RD  operand i is valid.
- fwd_hit_e  out  NUM_RD  operand i was taken from a bypass stage.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear to 0;
  - E latch clears: addresses 0, raw data 0;
  - rs_data_e=0, rs_ready_e=all 1, fwd_hit_e=0.
  - Reset mid-stall or mid-flush overrides everything.
- Write: on the clock edge with wb_we=1 and wb_addr≠0, regfile[wb_addr] ← wb_data. Writes to address 0 are dropped.
- Raw read (combinational, D side):
  - raw_i = 0 when rs_addr_d_i=0;
  - else wb_data when wb_we=1 and wb_addr=rs_addr_d_i (write-before-read);
  - else regfile[rs_addr_d_i].
- E latch, per rising edge, priority reset > flush > stall > normal:
  - flush=1: addresses ← 0, raw ← 0. Flush wins over a simultaneous stall.
  - stall=1: addresses held. Raw data re-read from the regfile at the held address, with the same write-before-read rule, so writebacks landing during a stall are never lost.
  - otherwise: addresses ← rs_addr_d, raw ← raw read.
- Bypass resolution (combinational, E side, per operand i, address a):
  - a=0 → data 0, ready 1, hit 0.
  - Otherwise scan k=0..NUM_STG-1. The first k with stg_we[k]=1 and stg_rd[k]=a wins: data = stg_data[k], ready = stg_dvalid[k], hit 1.
  - A younger matching stage always shadows older ones, even if the younger one is not ready.
  - No match → data = wb_data if wb_we=1 and wb_addr=a, else latched raw; ready 1; hit 0.
- Latency:
  - A writeback is visible to a D-stage read in the same cycle.
  - A bypass is visible to E in the same cycle.
  - Register-file write latency is 1 edge.
- The block never asserts stall itself. The hazard unit ORs ~rs_ready_e into its stall.
- Every output is a pure function of the E latch plus bypass inputs. No X propagates from an unwritten register, because of reset.

Test Plan:
- Reset, then wb x5=0xDEAD_BEEF; next cycle D reads x5 → after one edge rs_data_e=0xDEADBEEF, fwd_hit_e=0, ready=1.
- E holds x7; stg_we[0]=1, stg_rd[0]=7, data 0x11; stg_we[2]=1, stg_rd[2]=7, data 0x33 → rs_data_e=0x11, hit=1.
- E holds x9; stg_we[0]=1, stg_rd[0]=9, stg_dvalid[0]=0; stg[1] also matches x9 with valid data → rs_ready_e=0 (youngest shadows); drop stg[0]'s match → ready=1, data from stg[1].
- Stall held 3 cycles on x3; wb x3=0x42 during cycle 2 → operand reads 0x42 after that edge; release stall → next D address latched.
- Flush and stall asserted together → rs_addr_e=0, rs_data_e=0, ready=1.
- wb x0=0xFFFF_FFFF, stg_rd[0]=0 with stg_we[0]=1 → operand reading x0 stays 0, hit=0. Then assert reset asynchronously mid-cycle → outputs 0 immediately and x5 reads 0 afterwards.
